// File: rtl/lsu_ecc_wb_pkg.sv
// Shared types, sizing constants and the SECDED encoder for the DCCM ECC
// write-back (scrub) path.
package lsu_ecc_wb_pkg;

   localparam int ECC_WB_DEPTH      = 4;
   localparam int ECC_WB_ADDR_W     = 16;
   localparam int ECC_WB_DATA_W     = 32;
   localparam int ECC_WB_ECC_W      = 7;
   localparam int ECC_WB_STARVE_MAX = 15;

   // One queued repair: word address (byte offset stripped) and corrected data.
   typedef struct packed {
      logic [ECC_WB_ADDR_W-3:0] addr;
      logic [ECC_WB_DATA_W-1:0] data;
   } lsu_ecc_wb_pkt_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_REQ  = 2'd2
   } ecc_wb_state_t;

   // SECDED (39,32) check-bit generator, same code as the DC3 decoder:
   // six Hamming bits plus an overall parity bit.
   function automatic logic [ECC_WB_ECC_W-1:0] rvecc_encode(input logic [ECC_WB_DATA_W-1:0] din);
      logic [ECC_WB_ECC_W-1:0] ecc;
      ecc[0] = ^(din & 32'h56AA_AD5B);
      ecc[1] = ^(din & 32'h9B33_366D);
      ecc[2] = ^(din & 32'hE3C3_C78E);
      ecc[3] = ^(din & 32'h03FC_07F0);
      ecc[4] = ^(din & 32'h03FF_F800);
      ecc[5] = ^(din & 32'hFC00_0000);
      ecc[6] = ^{din, ecc[5:0]};
      return ecc;
   endfunction

endpackage

// File: rtl/lsu_ecc_wb.sv
// lsu_ecc_wb: collects single-bit-corrected load data from DC3, re-encodes the
// SECDED check bits and writes the repaired word back into DCCM through the
// write arbiter port shared with stbuf drain. Loads never stall on it.
module lsu_ecc_wb
   import lsu_ecc_wb_pkg::*;
#(
   parameter int DEPTH      = ECC_WB_DEPTH,
   parameter int STARVE_MAX = ECC_WB_STARVE_MAX
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ecc_disable,
   input  logic                     err_lo_valid,
   input  logic [ECC_WB_ADDR_W-1:0] err_lo_addr,
   input  logic [ECC_WB_DATA_W-1:0] err_lo_data,
   input  logic                     err_hi_valid,
   input  logic [ECC_WB_ADDR_W-1:0] err_hi_addr,
   input  logic [ECC_WB_DATA_W-1:0] err_hi_data,
   input  logic                     inv_valid,
   input  logic [ECC_WB_ADDR_W-1:0] inv_addr,
   output logic                     wr_valid,
   output logic [ECC_WB_ADDR_W-1:0] wr_addr,
   output logic [ECC_WB_DATA_W-1:0] wr_data,
   output logic [ECC_WB_ECC_W-1:0]  wr_ecc,
   input  logic                     wr_ready,
   output logic                     wr_urgent,
   output logic                     ovf_pulse,
   output logic                     busy
);

   localparam int IDX_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int SCNT_W = $clog2(STARVE_MAX + 1);
   localparam int WORD_W = ECC_WB_ADDR_W - 2;

   // Queue storage: entry 0 is the head; entries are kept compacted in age order.
   lsu_ecc_wb_pkt_t          q_r   [DEPTH];
   lsu_ecc_wb_pkt_t          q_n_s [DEPTH];
   logic [CNT_W-1:0]         cnt_r;
   logic [CNT_W-1:0]         cnt_n_s;
   ecc_wb_state_t            state_r;
   ecc_wb_state_t            state_n_s;
   logic [SCNT_W-1:0]        starve_r;
   logic [SCNT_W-1:0]        starve_n_s;

   logic                     wr_valid_r;
   logic [ECC_WB_ADDR_W-1:0] wr_addr_r;
   logic [ECC_WB_DATA_W-1:0] wr_data_r;
   logic [ECC_WB_ECC_W-1:0]  wr_ecc_r;
   logic                     wr_urgent_r;
   logic                     ovf_r;
   logic                     busy_r;

   logic                     hs_s;
   logic                     inflight_s;
   logic                     kill_head_s;
   logic                     head_gone_s;
   logic                     head_live_s;
   logic                     drop_s;
   logic                     hit_s;
   logic [WORD_W-1:0]        inv_word_s;
   logic                     push_valid_s [2];
   logic [WORD_W-1:0]        push_word_s  [2];
   logic [ECC_WB_DATA_W-1:0] push_data_s  [2];

   // Byte-offset bits select bytes inside a word and take no part in matching.
   logic                     unused_ok_s;
   assign unused_ok_s = ^{err_lo_addr[1:0], err_hi_addr[1:0], inv_addr[1:0]};

   assign inv_word_s      = inv_addr[ECC_WB_ADDR_W-1:2];
   assign push_valid_s[0] = err_lo_valid;
   assign push_word_s[0]  = err_lo_addr[ECC_WB_ADDR_W-1:2];
   assign push_data_s[0]  = err_lo_data;
   assign push_valid_s[1] = err_hi_valid;
   assign push_word_s[1]  = err_hi_addr[ECC_WB_ADDR_W-1:2];
   assign push_data_s[1]  = err_hi_data;

   // The head is in flight from the LOAD cycle until it is written or retired.
   // An invalidate hitting it without a handshake retires it unwritten.
   assign hs_s        = wr_valid_r & wr_ready;
   assign inflight_s  = (state_r != ST_IDLE);
   assign kill_head_s = hs_s | (inv_valid & (q_r[0].addr == inv_word_s));
   assign head_gone_s = inflight_s & kill_head_s;
   assign head_live_s = inflight_s & ~kill_head_s;

   // Queue next-state: drop popped/invalidated entries, compact, then merge or append lo, hi.
   always_comb begin
      logic match_v;
      logic keep_v;
      q_n_s   = q_r;
      cnt_n_s = {CNT_W{1'b0}};
      drop_s  = 1'b0;
      hit_s   = 1'b0;
      match_v = 1'b0;
      keep_v  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         keep_v = (CNT_W'(i) < cnt_r) &&
                  !(inv_valid && (q_r[i].addr == inv_word_s)) &&
                  !((i == 0) && hs_s);
         if (keep_v) begin
            q_n_s[cnt_n_s[IDX_W-1:0]] = q_r[i];
            cnt_n_s                   = cnt_n_s + CNT_W'(1);
         end else begin
            cnt_n_s = cnt_n_s;
         end
      end
      for (int k = 0; k < 2; k++) begin
         hit_s = 1'b0;
         // A store to the same word this cycle is newer than the corrected data.
         if (push_valid_s[k] && !ecc_disable &&
             !(inv_valid && (push_word_s[k] == inv_word_s))) begin
            for (int i = 0; i < DEPTH; i++) begin
               match_v = !hit_s && (CNT_W'(i) < cnt_n_s) &&
                         !((i == 0) && head_live_s) &&
                         (q_n_s[i].addr == push_word_s[k]);
               q_n_s[i].data = match_v ? push_data_s[k] : q_n_s[i].data;
               hit_s         = hit_s | match_v;
            end
            if (hit_s) begin
               drop_s = drop_s;
            end else if (cnt_n_s < CNT_W'(DEPTH)) begin
               q_n_s[cnt_n_s[IDX_W-1:0]].addr = push_word_s[k];
               q_n_s[cnt_n_s[IDX_W-1:0]].data = push_data_s[k];
               cnt_n_s                        = cnt_n_s + CNT_W'(1);
            end else begin
               drop_s = 1'b1;
            end
         end else begin
            hit_s = 1'b0;
         end
      end
   end

   // FSM next state: latch a head, present it, move on after handshake or retire.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         ST_IDLE: state_n_s = (cnt_n_s != {CNT_W{1'b0}}) ? ST_LOAD : ST_IDLE;
         ST_LOAD: state_n_s = head_gone_s ?
                              ((cnt_n_s != {CNT_W{1'b0}}) ? ST_LOAD : ST_IDLE) : ST_REQ;
         ST_REQ:  state_n_s = head_gone_s ?
                              ((cnt_n_s != {CNT_W{1'b0}}) ? ST_LOAD : ST_IDLE) : ST_REQ;
         default: state_n_s = ST_IDLE;
      endcase
   end

   // Starvation count: saturating count of REQ cycles spent waiting for a grant.
   always_comb begin
      starve_n_s = {SCNT_W{1'b0}};
      if ((state_r == ST_REQ) && (state_n_s == ST_REQ)) begin
         starve_n_s = (starve_r == SCNT_W'(STARVE_MAX)) ? starve_r : starve_r + SCNT_W'(1);
      end else begin
         starve_n_s = {SCNT_W{1'b0}};
      end
   end

   // Queue, FSM and starvation registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            q_r[i] <= {$bits(lsu_ecc_wb_pkt_t){1'b0}};
         end
         cnt_r    <= {CNT_W{1'b0}};
         state_r  <= ST_IDLE;
         starve_r <= {SCNT_W{1'b0}};
      end else begin
         q_r      <= q_n_s;
         cnt_r    <= cnt_n_s;
         state_r  <= state_n_s;
         starve_r <= starve_n_s;
      end
   end

   // Output registers; the write word and its fresh ECC are captured in LOAD and held through REQ.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_valid_r  <= 1'b0;
         wr_addr_r   <= {ECC_WB_ADDR_W{1'b0}};
         wr_data_r   <= {ECC_WB_DATA_W{1'b0}};
         wr_ecc_r    <= {ECC_WB_ECC_W{1'b0}};
         wr_urgent_r <= 1'b0;
         ovf_r       <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         wr_valid_r  <= (state_n_s == ST_REQ);
         wr_urgent_r <= (state_n_s == ST_REQ) && (starve_n_s == SCNT_W'(STARVE_MAX));
         ovf_r       <= drop_s;
         busy_r      <= (cnt_n_s != {CNT_W{1'b0}}) || (state_n_s != ST_IDLE);
         if ((state_r == ST_LOAD) && !head_gone_s) begin
            wr_addr_r <= {q_r[0].addr, 2'b00};
            wr_data_r <= q_r[0].data;
            wr_ecc_r  <= rvecc_encode(q_r[0].data);
         end
      end
   end

   assign wr_valid  = wr_valid_r;
   assign wr_addr   = wr_addr_r;
   assign wr_data   = wr_data_r;
   assign wr_ecc    = wr_ecc_r;
   assign wr_urgent = wr_urgent_r;
   assign ovf_pulse = ovf_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_lsu_ecc_wb.sv
// Bench for lsu_ecc_wb: directed scenarios followed by random traffic, each
// cycle compared against a queue-level reference model of the scrub unit.
module tb_lsu_ecc_wb;

   logic        clk;
   logic        rst, ecc_disable, err_lo_valid, err_hi_valid, inv_valid, wr_ready;
   logic [15:0] err_lo_addr, err_hi_addr, inv_addr;
   logic [31:0] err_lo_data, err_hi_data;
   logic        wr_valid, wr_urgent, ovf_pulse, busy;
   logic [15:0] wr_addr;
   logic [31:0] wr_data;
   logic [6:0]  wr_ecc;

   int n_pass, n_fail, n_checks;

   lsu_ecc_wb dut (
      .clk(clk), .rst(rst), .ecc_disable(ecc_disable),
      .err_lo_valid(err_lo_valid), .err_lo_addr(err_lo_addr), .err_lo_data(err_lo_data),
      .err_hi_valid(err_hi_valid), .err_hi_addr(err_hi_addr), .err_hi_data(err_hi_data),
      .inv_valid(inv_valid), .inv_addr(inv_addr),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ecc(wr_ecc),
      .wr_ready(wr_ready), .wr_urgent(wr_urgent), .ovf_pulse(ovf_pulse), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   typedef struct { logic [13:0] w; logic [31:0] d; } ent_t;
   ent_t        mq[$];        // pending repairs, oldest first
   int          m_stage;      // 0 idle, 1 fetching head, 2 presenting head
   int          m_starve;
   bit          m_was_rst;
   logic        e_valid, e_urg, e_ovf, e_busy;
   logic [15:0] e_addr;
   logic [31:0] e_data;
   logic [6:0]  e_ecc;

   // Hamming SECDED built from bit positions: data fills non-power-of-two slots.
   function automatic logic [6:0] ref_ecc(input logic [31:0] d);
      logic [6:0] c;
      int pos, j;
      c = 7'd0; pos = 3; j = 0;
      while (j < 32) begin
         if ((pos & (pos - 1)) != 0) begin
            for (int b = 0; b < 6; b++)
               if (((pos >> b) & 1) != 0) c[b] = c[b] ^ d[j];
            j++;
         end
         pos++;
      end
      c[6] = ^{d, c[5:0]};
      return c;
   endfunction

   task automatic model_step();
      bit hs, gone, live, hit, drop, v;
      int prev;
      logic [13:0] w, iw;
      logic [31:0] d;
      ent_t e;
      m_was_rst = rst;
      if (rst) begin
         mq.delete(); m_stage = 0; m_starve = 0;
         e_valid = 0; e_urg = 0; e_ovf = 0; e_busy = 0;
         e_addr = 16'h0; e_data = 32'h0; e_ecc = 7'h0;
         return;
      end
      iw   = inv_addr[15:2];
      hs   = (m_stage == 2) && wr_ready;
      gone = (m_stage != 0) && (mq.size() > 0) && (hs || (inv_valid && mq[0].w == iw));
      if (gone) void'(mq.pop_front());
      live = (m_stage != 0) && !gone;
      if (inv_valid)
         for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].w == iw) mq.delete(i);
      drop = 0;
      for (int k = 0; k < 2; k++) begin
         v = (k == 0) ? err_lo_valid : err_hi_valid;
         w = (k == 0) ? err_lo_addr[15:2] : err_hi_addr[15:2];
         d = (k == 0) ? err_lo_data : err_hi_data;
         if (v && !ecc_disable && !(inv_valid && w == iw)) begin
            hit = 0;
            for (int i = (live ? 1 : 0); i < mq.size(); i++)
               if (!hit && mq[i].w == w) begin mq[i].d = d; hit = 1; end
            if (!hit) begin
               if (mq.size() < 4) begin e.w = w; e.d = d; mq.push_back(e); end
               else drop = 1;
            end
         end
      end
      prev = m_stage;
      if (m_stage == 0) m_stage = (mq.size() > 0) ? 1 : 0;
      else if (gone) m_stage = (mq.size() > 0) ? 1 : 0;
      else if (m_stage == 1) begin
         m_stage = 2;
         e_addr = {mq[0].w, 2'b00}; e_data = mq[0].d; e_ecc = ref_ecc(mq[0].d);
      end
      m_starve = (prev == 2 && m_stage == 2) ? ((m_starve < 15) ? m_starve + 1 : 15) : 0;
      e_valid = (m_stage == 2);
      e_urg   = e_valid && (m_starve == 15);
      e_ovf   = drop;
      e_busy  = (mq.size() > 0) || (m_stage != 0);
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("wr_valid", {31'd0, wr_valid}, {31'd0, e_valid});
      chk("wr_urgent", {31'd0, wr_urgent}, {31'd0, e_urg});
      chk("ovf_pulse", {31'd0, ovf_pulse}, {31'd0, e_ovf});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      if (e_valid || m_was_rst) begin
         chk("wr_addr", {16'd0, wr_addr}, {16'd0, e_addr});
         chk("wr_data", wr_data, e_data);
         chk("wr_ecc", {25'd0, wr_ecc}, {25'd0, e_ecc});
      end
      rst = 1'b0; err_lo_valid = 1'b0; err_hi_valid = 1'b0; inv_valid = 1'b0;
   endtask

   task automatic set_lo(input logic [15:0] a, input logic [31:0] d);
      err_lo_valid = 1'b1; err_lo_addr = a; err_lo_data = d;
   endtask
   task automatic set_hi(input logic [15:0] a, input logic [31:0] d);
      err_hi_valid = 1'b1; err_hi_addr = a; err_hi_data = d;
   endtask
   task automatic set_inv(input logic [15:0] a);
      inv_valid = 1'b1; inv_addr = a;
   endtask

   function automatic logic [15:0] rnd_addr();
      logic [2:0] wd;
      logic [1:0] by;
      wd = 3'($urandom_range(0, 7));
      by = 2'($urandom_range(0, 3));
      return {11'h010, wd, by};
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      n_pass = 0; n_fail = 0; n_checks = 0;
      m_stage = 0; m_starve = 0; m_was_rst = 0; mq.delete();
      rst = 1'b1; ecc_disable = 1'b0; wr_ready = 1'b0;
      err_lo_valid = 1'b0; err_lo_addr = 16'h0; err_lo_data = 32'h0;
      err_hi_valid = 1'b0; err_hi_addr = 16'h0; err_hi_data = 32'h0;
      inv_valid = 1'b0; inv_addr = 16'h0;

      // reset state
      rst = 1'b1; tick();
      rst = 1'b1; tick();

      // single lo error, immediate grant: write at t+2, idle afterwards
      wr_ready = 1'b1;
      set_lo(16'h0104, 32'hDEAD_BEEF); tick();
      repeat (4) tick();

      // lo + hi in one cycle: two writes in order, one bubble between
      set_lo(16'h0010, 32'h1111_0010); set_hi(16'h0014, 32'h2222_0014); tick();
      repeat (6) tick();

      // five distinct errors with no grant: fifth dropped, then starvation
      wr_ready = 1'b0;
      set_lo(16'h0040, 32'hA000_0040); set_hi(16'h0044, 32'hA000_0044); tick();
      set_lo(16'h0048, 32'hA000_0048); set_hi(16'h004C, 32'hA000_004C); tick();
      set_lo(16'h0050, 32'hA000_0050); tick();
      repeat (18) tick();
      wr_ready = 1'b1;
      repeat (10) tick();

      // invalidate a queued entry, then the in-flight one
      wr_ready = 1'b0;
      set_lo(16'h0060, 32'hB000_0060); tick();
      set_lo(16'h0020, 32'hB000_0020); tick();
      tick();
      set_inv(16'h0022); tick();
      tick();
      set_inv(16'h0060); tick();
      repeat (3) tick();
      wr_ready = 1'b1;
      repeat (4) tick();

      // same word twice before issue: one write of the newer data; push+inv same word discarded
      wr_ready = 1'b0;
      set_lo(16'h0070, 32'hC000_0070); tick();
      set_lo(16'h0030, 32'h0000_000A); tick();
      set_lo(16'h0030, 32'h0000_000B); tick();
      set_lo(16'h0034, 32'h0000_0034); set_inv(16'h0035); tick();
      tick();
      wr_ready = 1'b1;
      repeat (8) tick();

      // reset during REQ with three entries queued
      wr_ready = 1'b0;
      set_lo(16'h0080, 32'hD000_0080); set_hi(16'h0084, 32'hD000_0084); tick();
      set_lo(16'h0088, 32'hD000_0088); tick();
      repeat (3) tick();
      rst = 1'b1; tick();
      repeat (3) tick();

      // ECC disabled: errors ignored without overflow
      wr_ready = 1'b1; ecc_disable = 1'b1;
      set_lo(16'h0090, 32'hE000_0090); set_hi(16'h0094, 32'hE000_0094); tick();
      repeat (4) tick();
      ecc_disable = 1'b0;

      // random traffic on a small address pool to provoke merges, kills and overflow
      repeat (800) begin
         wr_ready    = ($urandom_range(0, 3) != 0);
         ecc_disable = ($urandom_range(0, 15) == 0);
         rst         = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 2) == 0) set_lo(rnd_addr(), $urandom());
         if ($urandom_range(0, 3) == 0) set_hi(rnd_addr(), $urandom());
         if ($urandom_range(0, 5) == 0) set_inv(rnd_addr());
         tick();
      end
      ecc_disable = 1'b0;
      wr_ready = 1'b1;
      repeat (12) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
